// File: rtl/seq_divider_16.sv
// seq_divider_16 -- sequential signed divider (radix-2 restoring).
//
// Divides a two's-complement dividend by a two's-complement divisor using
// operand magnitudes, one quotient bit per cycle, then applies sign
// correction. Division truncates toward zero; the remainder takes the sign
// of the dividend. The result appears WIDTH+1 cycles after a start is
// accepted, together with a one-cycle done pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   start      request, accepted only while idle (busy=0)
//   dividend   two's-complement dividend, sampled with start
//   divisor    two's-complement divisor, sampled with start
//   quotient   signed quotient, held until the next completion
//   remainder  signed remainder, held until the next completion
//   busy       high from the cycle after acceptance until the done cycle
//   done       one-cycle pulse, results valid from this cycle
//   div_zero   divide-by-zero flag, valid with done
//
// Optional feature macro: DIV_ZERO_DETECT_EN
//   defined   : a zero divisor skips the iteration, completes 2 cycles after
//               acceptance with quotient=FFFF, remainder=dividend, div_zero=1
//   undefined : no detection; a zero divisor runs the normal iteration and
//               div_zero is tied low

module seq_divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  // Datapath registers (not reset: only meaningful after an accepted start)
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sign_q;
  logic             r_sign_r;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_sub;
  logic             w_fits;

  // Magnitude of a two's-complement value; the most negative value maps to
  // 2^(WIDTH-1), which is still representable as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] f_neg_cond(input logic             neg,
                                                  input logic [WIDTH-1:0] v);
    return neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // The shifted partial remainder needs WIDTH+1 bits. After each step the
  // kept remainder is below |divisor| <= 2^(WIDTH-1), so WIDTH bits suffice
  // for storage, and the difference (when it fits) is also below 2^WIDTH.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_fits  = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;

`ifdef DIV_ZERO_DETECT_EN
  logic r_dz;
  logic r_div_zero;
  logic w_dvs_zero;
  logic w_dz_hold;

  assign w_dvs_zero = (divisor == {WIDTH{1'b0}});
  // A zero-divisor request spends two cycles in SIGN so that done lands
  // two cycles after acceptance; the counter marks the first of them.
  assign w_dz_hold  = r_dz && (r_cnt == {CW{1'b0}});
  assign div_zero   = r_div_zero;
`else
  assign div_zero   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_DETECT_EN
          w_next = w_dvs_zero ? S_SIGN : S_CALC;
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (w_last) w_next = S_SIGN;
      end
      S_SIGN: begin
`ifdef DIV_ZERO_DETECT_EN
        w_next = w_dz_hold ? S_SIGN : S_IDLE;
`else
        w_next = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= {CW{1'b0}};
      r_done      <= 1'b0;
      r_quotient  <= {WIDTH{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
`ifdef DIV_ZERO_DETECT_EN
      r_dz        <= 1'b0;
      r_div_zero  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= {CW{1'b0}};
`ifdef DIV_ZERO_DETECT_EN
            r_dz  <= w_dvs_zero;
`endif
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_SIGN: begin
`ifdef DIV_ZERO_DETECT_EN
          if (w_dz_hold) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_div_zero <= r_dz;
`else
          begin
`endif
            r_quotient  <= f_neg_cond(r_sign_q, r_quo);
            r_remainder <= f_neg_cond(r_sign_r, r_rem);
            r_done      <= 1'b1;
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  // Iteration datapath: load magnitudes on accept, one quotient bit per CALC cycle
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dvs    <= f_abs(divisor);
      r_sign_r <= dividend[WIDTH-1];
`ifdef DIV_ZERO_DETECT_EN
      if (w_dvs_zero) begin
        // Preload the final state directly: all-ones quotient with no sign
        // flip, and |dividend| as remainder so sign correction restores it.
        r_quo    <= {WIDTH{1'b1}};
        r_rem    <= f_abs(dividend);
        r_sign_q <= 1'b0;
      end else begin
        r_quo    <= f_abs(dividend);
        r_rem    <= {WIDTH{1'b0}};
        r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      end
`else
      r_quo    <= f_abs(dividend);
      r_rem    <= {WIDTH{1'b0}};
      r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
`endif
    end else if (r_state == S_CALC) begin
      r_rem <= w_fits ? w_sub : w_shift[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_fits};
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_seq_divider_16.sv
// Testbench for seq_divider_16: directed cases plus a randomized signed
// sweep, checked by a scoreboard against a truncating-division model.

module tb_seq_divider_16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  seq_divider_16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: signed integer division truncates toward zero and the
  // remainder follows the dividend's sign.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   ia;
    int   ib;
    ia    = int'($signed(a));
    ib    = int'($signed(b));
    e.a   = a;
    e.b   = b;
    e.acc = 0;
    if (ib == 0) begin
`ifdef DIV_ZERO_DETECT_EN
      e.q   = 16'hFFFF;
      e.dz  = 1'b1;
      e.lat = 2;
`else
      e.q   = (ia >= 0) ? 16'hFFFF : 16'h0001;
      e.dz  = 1'b0;
      e.lat = 17;
`endif
      e.r = a;
    end else begin
      e.q   = 16'(ia / ib);
      e.r   = 16'(ia % ib);
      e.dz  = 1'b0;
      e.lat = 17;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with q=%h r=%h, required no done", quotient, remainder);
      end else begin
        e = sb.pop_front();
        chk($sformatf("quot %h/%h", e.a, e.b), quotient, e.q);
        chk($sformatf("rem %h/%h", e.a, e.b), remainder, e.r);
        chk($sformatf("divzero %h/%h", e.a, e.b), div_zero, e.dz);
        chk($sformatf("latency %h/%h", e.a, e.b), cyc - e.acc, e.lat);
      end
    end
  end

  // Call at a falling edge; returns just after the accepting rising edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e        = model(a, b);
    e.acc    = cyc + 1;
    sb.push_back(e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the falling edge on which done is seen (the done cycle).
  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 40);
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done in %0d cycles, required done", n);
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  int dv[10] = '{-100,  100, -100, -32768, -32768, 5, 1234, -5, 32767, 0};
  int ds[10] = '{   7,   -7,   -7,     -1,      1, 9,    0,  0, -32768, 5};

  initial begin : stim
    int          bc;
    int          n;
    logic [15:0] ra;
    logic [15:0] rb;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 16'd0;
    #1;
    chk("reset_quotient",  quotient,  16'd0);
    chk("reset_remainder", remainder, 16'd0);
    chk("reset_busy",      busy,      1'b0);
    chk("reset_done",      done,      1'b0);
    chk("reset_divzero",   div_zero,  1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 100/7 with busy window measurement
    issue(16'd100, 16'd7);
    bc = 0;
    n  = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
      if (busy === 1'b1) bc++;
    end
    chk("busy_cycles", bc, 17);
    chk("busy_in_done_cycle", busy, 1'b0);
    chk("done_seen", done, 1'b1);

    // Directed sign, overflow, small and zero-divisor cases, back-to-back
    for (int i = 0; i < 10; i++) begin
      issue(16'(dv[i]), 16'(ds[i]));
      wait_done();
    end

    // Start while busy is ignored; reissue in the done cycle is accepted
    issue(16'd50, 16'd3);
    repeat (4) @(negedge clk);
    start    = 1'b1;
    dividend = 16'd9;
    divisor  = 16'd2;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    issue(16'd9, 16'd2);
    wait_done();

    // Reset mid-operation: outputs clear at once and no done follows
    repeat (2) @(negedge clk);
    issue(16'd1000, 16'd3);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_quotient",  quotient,  16'd0);
    chk("midrst_remainder", remainder, 16'd0);
    chk("midrst_busy",      busy,      1'b0);
    chk("midrst_done",      done,      1'b0);
    chk("midrst_divzero",   div_zero,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(16'd77, 16'd7);
    wait_done();

    // Randomized signed sweep, back-to-back
    for (int i = 0; i < 3000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          rb = 16'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        1: ra = 16'h8000;
        2: rb = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h8000;
        default: ;
      endcase
      if (rb == 16'd0) rb = 16'd1;
      issue(ra, rb);
      wait_done();
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
